// File: rtl/writeback_regfile_mp.sv
// writeback_regfile_mp: LC3 writeback stage with an integrated multi-read-port
// register file. Selects the writeback source, commits it to R[dr], updates the
// NZP flags and serves NUM_RD_PORTS registered operand reads.
// Optional macro WB_BYPASS_EN: on a same-edge read of the register being
// written, the read port captures the new value instead of the old one.
module writeback_regfile_mp #(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 8,
  parameter int NUM_RD_PORTS = 2,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable_writeback,
  input  logic [1:0]                      W_Control,
  input  logic [DATA_W-1:0]               aluout,
  input  logic [DATA_W-1:0]               pcout,
  input  logic [DATA_W-1:0]               memout,
  input  logic [AW-1:0]                   dr,
  input  logic [NUM_RD_PORTS*AW-1:0]      sr,
  output logic [NUM_RD_PORTS*DATA_W-1:0]  VSR,
  output logic [2:0]                      psr,
  output logic                            enable_writeback_status,
  output logic [15:0]                     wb_count,
  output logic                            illegal_sel
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;
  logic              illegal;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        nzp;

  // Source select, commit qualification and NZP classification of the write value.
  always_comb begin
    commit  = enable_writeback && (W_Control != 2'd3);
    illegal = enable_writeback && (W_Control == 2'd3);
    wdata   = aluout;
    case (W_Control)
      2'd1:    wdata = pcout;
      2'd2:    wdata = memout;
      default: wdata = aluout;
    endcase
    if (wdata[DATA_W-1])
      nzp = 3'b100;
    else if (wdata == '0)
      nzp = 3'b010;
    else
      nzp = 3'b001;
  end

  // Register file write port; reset discards any write in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (commit) begin
      regs[dr] <= wdata;
    end
  end

  // Registered read ports; each port is independent and may alias another.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      VSR <= '0;
    end else begin
      for (int k = 0; k < NUM_RD_PORTS; k++) begin
`ifdef WB_BYPASS_EN
        if (commit && (sr[k*AW +: AW] == dr))
          VSR[k*DATA_W +: DATA_W] <= wdata;
        else
          VSR[k*DATA_W +: DATA_W] <= regs[sr[k*AW +: AW]];
`else
        VSR[k*DATA_W +: DATA_W] <= regs[sr[k*AW +: AW]];
`endif
      end
    end
  end

  // Condition codes, commit status, commit counter and sticky illegal flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psr                     <= 3'b000;
      enable_writeback_status <= 1'b0;
      wb_count                <= 16'd0;
      illegal_sel             <= 1'b0;
    end else begin
      enable_writeback_status <= commit;
      if (commit) begin
        psr      <= nzp;
        wb_count <= wb_count + 16'd1;
      end
      if (illegal)
        illegal_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_regfile_mp.sv
// tb_writeback_regfile_mp: directed and randomized checks of the writeback
// register file against an array-based reference model.
module tb_writeback_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NP = 3;
  localparam int AW = $clog2(NR);

  logic                 clock;
  logic                 reset;
  logic                 en;
  logic [1:0]           wc;
  logic [DW-1:0]        alu, pc, mem;
  logic [AW-1:0]        d;
  logic [NP*AW-1:0]     sr;
  logic [NP*DW-1:0]     vsr;
  logic [2:0]           psr;
  logic                 status;
  logic [15:0]          cnt;
  logic                 ill;

  writeback_regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable_writeback       (en),
    .W_Control              (wc),
    .aluout                 (alu),
    .pcout                  (pc),
    .memout                 (mem),
    .dr                     (d),
    .sr                     (sr),
    .VSR                    (vsr),
    .psr                    (psr),
    .enable_writeback_status(status),
    .wb_count               (cnt),
    .illegal_sel            (ill)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] m_vsr [NP];
  logic [2:0]    m_psr;
  logic [15:0]   m_cnt;
  logic          m_ill;
  logic          m_status;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP*AW-1:0] mk_sr(input int a, input int b, input int c);
    logic [AW-1:0] pa, pb, pc_;
    pa = AW'(a); pb = AW'(b); pc_ = AW'(c);
    return {pc_, pb, pa};
  endfunction

  function automatic logic [DW-1:0] port(input int k);
    logic [NP*DW-1:0] v;
    v = vsr;
    return v[k*DW +: DW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    for (int k = 0; k < NP; k++) m_vsr[k] = '0;
    m_psr = 3'b000; m_cnt = 16'd0; m_ill = 1'b0; m_status = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    for (int k = 0; k < NP; k++)
      check($sformatf("%s_vsr%0d", pfx, k), port(k), m_vsr[k]);
    check({pfx, "_psr"}, psr, m_psr);
    check({pfx, "_status"}, status, m_status);
    check({pfx, "_count"}, cnt, m_cnt);
    check({pfx, "_illegal"}, ill, m_ill);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_vsr"}, vsr, '0);
    check({pfx, "_psr"}, psr, 3'b000);
    check({pfx, "_status"}, status, 1'b0);
    check({pfx, "_count"}, cnt, 16'd0);
    check({pfx, "_illegal"}, ill, 1'b0);
  endtask

  // One clock: called just after a falling edge, drives inputs, predicts, samples at next falling edge.
  task automatic cycle(input logic e, input logic [1:0] w, input logic [DW-1:0] a,
                       input logic [DW-1:0] p, input logic [DW-1:0] m,
                       input logic [AW-1:0] dd, input logic [NP*AW-1:0] s, input string pfx);
    logic          committed;
    logic [DW-1:0] val;
    en = e; wc = w; alu = a; pc = p; mem = m; d = dd; sr = s;
    committed = e && (w != 2'd3);
    val = (w == 2'd1) ? p : (w == 2'd2) ? m : a;
    for (int k = 0; k < NP; k++) begin
      int addr;
      addr = int'(s[k*AW +: AW]);
      m_vsr[k] = mdl[addr];
`ifdef WB_BYPASS_EN
      if (committed && addr == int'(dd)) m_vsr[k] = val;
`endif
    end
    if (committed) begin
      mdl[dd] = val;
      if (val[DW-1])   m_psr = 3'b100;
      else if (val == 0) m_psr = 3'b010;
      else             m_psr = 3'b001;
      m_cnt = m_cnt + 16'd1;
    end
    if (e && w == 2'd3) m_ill = 1'b1;
    m_status = committed;
    @(posedge clock);
    @(negedge clock);
    check_all(pfx);
  endtask

  // Asserts reset between edges while a write is being presented.
  task automatic do_reset(input string pfx);
    en = 1'b1; wc = 2'($urandom_range(0, 2)); alu = $urandom; pc = $urandom; mem = $urandom;
    d = AW'($urandom); sr = NP*AW'($urandom);
    #2 reset = 1'b0;
    #1 check_zero({pfx, "_async"});
    model_clear();
    @(posedge clock);
    #1 check_zero({pfx, "_held"});
    @(negedge clock);
    reset = 1'b1;
    en = 1'b0;
  endtask

  initial begin
    int prev_cnt;
    reset = 1'b0; en = 1'b0; wc = 2'd0; alu = '0; pc = '0; mem = '0; d = '0; sr = '0;
    model_clear();
    repeat (2) @(negedge clock);
    check_zero("rst_init");
    reset = 1'b1;

    // all registers read back zero after reset
    for (int r = 0; r < NR; r += NP)
      cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(r, (r + 1) % NR, (r + 2) % NR), "rd_reset");

    // negative ALU write
    cycle(1'b1, 2'd0, 32'h8000_0001, '0, '0, 4'd3, mk_sr(0, 0, 0), "neg_wr");
    check("neg_status", status, 1'b1);
    check("neg_count", cnt, 16'd1);
    check("neg_psr", psr, 3'b100);
    cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(3, 0, 0), "neg_rd");
    check("neg_vsr0", port(0), 32'h8000_0001);
    check("neg_status_drop", status, 1'b0);

    // zero memory load then positive PC value
    cycle(1'b1, 2'd2, 32'h5555_5555, 32'h6666_6666, '0, 4'd5, mk_sr(0, 0, 0), "zero_wr");
    check("zero_psr", psr, 3'b010);
    cycle(1'b1, 2'd1, 32'h7777_7777, 32'h0000_0042, 32'h9999_9999, 4'd6, mk_sr(0, 0, 0), "pos_wr");
    check("pos_psr", psr, 3'b001);
    cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(5, 6, 6), "zp_rd");
    check("zp_vsr0", port(0), 32'h0);
    check("zp_vsr1", port(1), 32'h0000_0042);

    // illegal select leaves state untouched but sets the sticky flag
    prev_cnt = int'(cnt);
    cycle(1'b1, 2'd3, 32'h0000_1234, '0, '0, 4'd2, mk_sr(2, 2, 2), "ill_wr");
    check("ill_flag", ill, 1'b1);
    check("ill_count", cnt, 16'(prev_cnt));
    check("ill_psr", psr, 3'b001);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
            AW'($urandom_range(3, NR - 1)), mk_sr(2, 0, 1), "ill_legal");
    check("ill_sticky", ill, 1'b1);
    check("ill_r2", port(0), 32'h0);

    // same-edge read of the register being written
    cycle(1'b1, 2'd0, 32'h0000_0011, '0, '0, 4'd1, mk_sr(0, 0, 0), "rdw_pre");
    cycle(1'b1, 2'd0, 32'h0000_00AA, '0, '0, 4'd1, mk_sr(1, 1, 0), "rdw");
`ifdef WB_BYPASS_EN
    check("rdw_vsr0", port(0), 32'h0000_00AA);
`else
    check("rdw_vsr0", port(0), 32'h0000_0011);
`endif
    cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(1, 1, 1), "rdw_after");
    check("rdw_new", port(2), 32'h0000_00AA);

    // async reset mid-write discards it
    do_reset("rst_mid");
    cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(int'(d), 0, 0), "rst_discard");

    // top register, all ports alias
    cycle(1'b1, 2'd0, 32'hFFFF_FFFF, '0, '0, 4'd15, mk_sr(0, 0, 0), "r15_wr");
    cycle(1'b0, 2'd0, '0, '0, '0, '0, mk_sr(15, 15, 15), "r15_rd");
    for (int k = 0; k < NP; k++) check($sformatf("r15_vsr%0d", k), port(k), 32'hFFFF_FFFF);
    check("r15_psr", psr, 3'b100);

    // randomized traffic with occasional async resets
    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0]    rd;
      logic [NP*AW-1:0] s;
      logic [1:0]       w;
      if (i % 400 == 399) do_reset("rnd_rst");
      rd = AW'($urandom);
      for (int k = 0; k < NP; k++)
        s[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom);
      w = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, rd, s, "rnd");
    end

    // counter wrap after 65536 commits
    do_reset("wrap_rst");
    for (int i = 0; i < 65536; i++)
      cycle(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
            AW'($urandom), NP*AW'($urandom), "wrap");
    check("wrap_count", cnt, 16'd0);
    check("wrap_status", status, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
